serial_subtractor12: RTL and testbench

- Multi-cycle, bit-serial 12-bit subtractor: D = A - B - BIN.
- Complements the team's combinational 12-bit adder datapath and reuses a single full-adder cell, fed with inverted B bits, over 12 clocks.
- Valid/ready handshakes on both input and output, so it can sit between producer and consumer stages of lab datapaths.
- Also reports borrow, zero and signed-overflow flags.

---
 rtl/serial_subtractor12.sv | 83 ++++++++
 tb/tb_serial_subtractor12.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor12.sv
// serial_subtractor12: bit-serial WIDTH-bit subtractor d = a - b - bin with valid/ready handshakes and flags
module serial_subtractor12 #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, res, res_n;
  logic [CW-1:0] count;
  logic carry, a_msb, b_msb, s, c_n, last;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // one full-adder cell on a[i] + ~b[i] + carry; result fills from the MSB end
  always_comb begin
    s     = sa[0] ^ ~sb[0] ^ carry;
    c_n   = (sa[0] & ~sb[0]) | (sa[0] & carry) | (~sb[0] & carry);
    res_n = {s, res[WIDTH-1:1]};
    last  = count == CW'(WIDTH - 1);
  end
  // next-state: accept in IDLE, 12 RUN edges, hold DONE until the consumer takes it
  always_comb begin
    state_n = (state == IDLE && in_valid)  ? RUN  :
              (state == RUN && last)       ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // datapath: latch operands on accept, shift during RUN, publish result on the last RUN edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      count <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sa    <= a;
      sb    <= b;
      res   <= '0;
      count <= '0;
      carry <= ~bin;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= res_n;
      carry <= c_n;
      count <= count + CW'(1);
      if (last) begin
        d    <= res_n;
        bout <= ~c_n;
        zero <= res_n == '0;
        ovf  <= (a_msb != b_msb) && (s != a_msb);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor12.sv
// tb_serial_subtractor12: self-checking bench with directed vectors, random ops, backpressure and mid-run reset
module tb_serial_subtractor12;
  logic clk, rst, in_valid, in_ready, bin, out_valid, out_ready, bout, zero, ovf, busy;
  logic [11:0] a, b, d;
  int tests = 0, fails = 0;

  serial_subtractor12 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .zero(zero), .ovf(ovf), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // reference: plain 13-bit arithmetic, flags packed as {ovf, zero, bout, d}
  function automatic logic [14:0] model(input logic [11:0] ma, mb, input logic mbin);
    logic [12:0] full;
    logic [11:0] md;
    full = {1'b0, ma} - {1'b0, mb} - {12'd0, mbin};
    md = full[11:0];
    return {(ma[11] != mb[11]) && (md[11] != ma[11]), md == 12'd0, full[12], md};
  endfunction

  // drive one operand pair from IDLE and wait (bounded) for out_valid
  task automatic do_op(input logic [11:0] ta, tb, input logic tbin, output int lat);
    in_valid = 1; a = ta; b = tb; bin = tbin;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; bin = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tests++;
    if ({in_ready, out_valid, busy, d, bout, zero, ovf} !== {3'b100, 12'd0, 3'b000}) begin
      fails++;
      $display("FAIL reset: got rdy=%b vld=%b busy=%b d=%h b=%b z=%b o=%b, expected rdy=1 vld=0 busy=0 d=000 flags=0",
               in_ready, out_valid, busy, d, bout, zero, ovf);
    end
  endtask

  logic [11:0] va [6] = '{12'h064, 12'h000, 12'h005, 12'h800, 12'h7FF, 12'h123};
  logic [11:0] vb [6] = '{12'h025, 12'h001, 12'h005, 12'h001, 12'hFFF, 12'h122};
  logic        vi [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [14:0] ve [6] = '{{3'b000, 12'h03F}, {3'b001, 12'hFFF}, {3'b001, 12'hFFF},
                          {3'b100, 12'h7FF}, {3'b101, 12'h800}, {3'b010, 12'h000}};

  task automatic test_vectors;
    int lat;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vi[i], lat);
      tests++;
      if (lat !== 12) begin
        fails++;
        $display("FAIL vec%0d latency: got %0d cycles, expected 12", i, lat);
      end
      tests++;
      if ({ovf, zero, bout, d} !== ve[i]) begin
        fails++;
        $display("FAIL vec%0d result: a=%h b=%h bin=%b got o/z/b/d=%b%b%b/%h expected %b/%h",
                 i, va[i], vb[i], vi[i], ovf, zero, bout, d, ve[i][14:12], ve[i][11:0]);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL vec%0d pulse: got vld=%b rdy=%b after handshake, expected vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random;
    int lat;
    logic [11:0] ra, rb;
    logic rbin;
    logic [14:0] exp;
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      ra = 12'($urandom); rb = 12'($urandom); rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      exp = model(ra, rb, rbin);
      do_op(ra, rb, rbin, lat);
      tests++;
      if (lat !== 12 || {ovf, zero, bout, d} !== exp) begin
        fails++;
        $display("FAIL random%0d: a=%h b=%h bin=%b got lat=%0d o/z/b/d=%b%b%b/%h expected lat=12 %b/%h",
                 i, ra, rb, rbin, lat, ovf, zero, bout, d, exp[14:12], exp[11:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [14:0] exp;
    out_ready = 0;
    exp = model(12'h321, 12'h456, 1'b0);
    do_op(12'h321, 12'h456, 1'b0, lat);
    tests++;
    if (lat !== 12 || {ovf, zero, bout, d} !== exp) begin
      fails++;
      $display("FAIL bp_result: got lat=%0d o/z/b/d=%b%b%b/%h expected lat=12 %b/%h",
               lat, ovf, zero, bout, d, exp[14:12], exp[11:0]);
    end
    in_valid = 1; a = 12'h111; b = 12'h001; bin = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, zero, bout, d} !== exp) begin
        fails++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b o/z/b/d=%b%b%b/%h expected vld=1 rdy=0 %b/%h",
                 i, out_valid, in_ready, ovf, zero, bout, d, exp[14:12], exp[11:0]);
      end
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || {ovf, zero, bout, d} !== exp) begin
      fails++;
      $display("FAIL bp_release: got vld=%b rdy=%b busy=%b d=%h expected vld=0 rdy=1 busy=0 d=%h",
               out_valid, in_ready, busy, d, exp[11:0]);
    end
    exp = model(12'h0F0, 12'h00F, 1'b1);
    do_op(12'h0F0, 12'h00F, 1'b1, lat);
    tests++;
    if (lat !== 12 || {ovf, zero, bout, d} !== exp) begin
      fails++;
      $display("FAIL bp_next: got lat=%0d d=%h expected lat=12 d=%h", lat, d, exp[11:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    int lat;
    bit seen;
    out_ready = 1;
    in_valid = 1; a = 12'hABC; b = 12'h123; bin = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || d !== 12'd0) begin
      fails++;
      $display("FAIL mid_reset: got rdy=%b busy=%b vld=%b d=%h expected rdy=1 busy=0 vld=0 d=000",
               in_ready, busy, out_valid, d);
    end
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL mid_reset_novalid: got out_valid=1 after abort, expected 0");
    end
    do_op(12'hABC, 12'h123, 1'b0, lat);
    tests++;
    if (lat !== 12 || d !== 12'h999 || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_fresh: got lat=%0d d=%h b=%b o=%b z=%b expected lat=12 d=999 b=0 o=0 z=0",
               lat, d, bout, ovf, zero);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_random;
    test_backpressure;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
